mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  input  1  clock; all state updates on rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high.
REQ-003 exe_to_mem_valid  input  1  upstream holds a valid instruction.
REQ-004 exe_to_mem_bus  input  74  {ld_type[2:0], res_from_mem, gr_we, dest[4:0], alu_result[31:0], pc[31:0]}, MSB first.
REQ-005 mem_allowin  output  1  stage can accept an instruction this cycle.
REQ-006 mem_to_wb_valid  output  1  stage offers a completed instruction downstream.
REQ-007 mem_to_wb_bus  output  70  {gr_we, dest[4:0], final_result[31:0], pc[31:0]}, MSB first.
REQ-008 wb_allowin  input  1  downstream accepts this cycle.
REQ-009 data_sram_data_ok  input  1  load response valid this cycle; responses arrive in order.
REQ-010 data_sram_rdata  input  32  load response word.
REQ-011 gr_we_mem  output  1  held instruction writes the register file (0 when stage empty).
REQ-012 dest_mem  output  5  destination register (0 when stage empty).
REQ-013 forward_data_mem  output  32  bypass value (0 when stage empty).
REQ-014 mem_load_pending  output  1  held load has no data yet; decode must stall a dependent instruction.

Function
REQ-015 Transfer into stage SHALL occur when exe_to_mem_valid and mem_allowin; transfer out when mem_to_wb_valid and wb_allowin.
REQ-016 mem_allowin SHALL equal !mem_valid | (mem_ready_go & wb_allowin).
REQ-017 mem_to_wb_valid SHALL equal mem_valid & mem_ready_go.
REQ-018 Bus register SHALL load only on an inbound transfer; held otherwise.
REQ-019 States: EMPTY, WAIT (load, no data), READY (non-load, or load data buffered).
REQ-020 EMPTY->READY on inbound non-load; EMPTY->WAIT on inbound load.
REQ-021 WAIT->READY when data_sram_data_ok; rdata captured into 32-bit buffer that cycle.
REQ-022 mem_ready_go SHALL be 1 in READY, and 1 in WAIT in the cycle data_ok is high (data forwarded combinationally from rdata).
REQ-023 On outbound transfer without inbound: next state EMPTY; with simultaneous inbound: next state per REQ-020.
REQ-024 READY with !wb_allowin SHALL hold state, bus and buffer unchanged indefinitely.
REQ-025 data_sram_data_ok in EMPTY or READY SHALL be ignored; no state change, buffer unchanged.
REQ-026 Load extract by alu_result[1:0]: ld_type 000 LW word; 001 LB sign-ext byte; 010 LBU zero-ext byte; 011 LH sign-ext half at addr[1]; 100 LHU zero-ext half; 101-111 treated as LW.
REQ-027 final_result SHALL be extracted load data when res_from_mem, else alu_result.
REQ-028 mem_load_pending SHALL be 1 exactly in WAIT with data_ok low.
REQ-029 forward_data_mem SHALL equal final_result when mem_valid, else 0; meaningful only when mem_load_pending is 0.
REQ-030 Latency: non-load 1 cycle from entry to mem_to_wb_valid; load = response delay, minimum same cycle as data_ok.

Reset
REQ-031 reset SHALL force state EMPTY, mem_valid 0, buffer-valid 0; mem_to_wb_valid, gr_we_mem, mem_load_pending 0; dest_mem, forward_data_mem 0; mem_allowin 1 following cycle.
REQ-032 Reset during WAIT SHALL discard the load; a data_ok arriving after reset SHALL be ignored per REQ-025.
REQ-033 Bus register and data buffer contents need not be reset.

Structure
REQ-034 EXE_TO_MEM_BUS_WD (74), MEM_TO_WB_BUS_WD (70) and ld_type encodings SHALL live in the shared CPU header.
REQ-035 Load byte/halfword extraction SHALL be one combinational sub-module, load_align.

Verification
REQ-036 ALU op, gr_we=1, dest=5, alu_result=0x12345678, wb_allowin=1 -> next cycle mem_to_wb_valid=1, final_result 0x12345678, forward_data_mem 0x12345678.
REQ-037 LB at addr[1:0]=3, data_ok 2 cycles later with rdata 0x80FF0011 -> mem_load_pending 1 for 2 cycles, final_result 0xFFFFFF80.
REQ-038 LHU at addr[1:0]=2, rdata 0x8001ABCD, data_ok same cycle wb_allowin=0 for 3 cycles -> buffer holds, final_result 0x00008001 stable, mem_allowin 0 until wb accepts.
REQ-039 Back-to-back ALU ops with wb_allowin=1 -> one per cycle, no bubbles; wb_allowin toggling -> no drop, no duplicate.
REQ-040 Stray data_ok in EMPTY with rdata 0xDEADBEEF -> no output change, next load uses its own response.
REQ-041 Reset asserted in WAIT, data_ok next cycle -> mem_to_wb_valid stays 0, mem_allowin 1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared CPU header for the memory stage: bus widths, load encodings, bus payloads, FSM states.
package mem_stage_pkg;

    localparam int unsigned EXE_TO_MEM_BUS_WD = 74;
    localparam int unsigned MEM_TO_WB_BUS_WD  = 70;
    localparam int unsigned DATA_WD           = 32;
    localparam int unsigned REG_ADDR_WD       = 5;
    localparam int unsigned LD_TYPE_WD        = 3;

    // Load type encodings; 101-111 behave as a word load
    localparam logic [LD_TYPE_WD-1:0] LD_W  = 3'b000;
    localparam logic [LD_TYPE_WD-1:0] LD_B  = 3'b001;
    localparam logic [LD_TYPE_WD-1:0] LD_BU = 3'b010;
    localparam logic [LD_TYPE_WD-1:0] LD_H  = 3'b011;
    localparam logic [LD_TYPE_WD-1:0] LD_HU = 3'b100;

    typedef struct packed {
        logic [LD_TYPE_WD-1:0]  ld_type;
        logic                   res_from_mem;
        logic                   gr_we;
        logic [REG_ADDR_WD-1:0] dest;
        logic [DATA_WD-1:0]     alu_result;
        logic [DATA_WD-1:0]     pc;
    } exe_to_mem_t;

    typedef struct packed {
        logic                   gr_we;
        logic [REG_ADDR_WD-1:0] dest;
        logic [DATA_WD-1:0]     final_result;
        logic [DATA_WD-1:0]     pc;
    } mem_to_wb_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Memory stage connections: upstream/downstream handshakes, load response and bypass taps.
interface mem_stage_if
    import mem_stage_pkg::*;
();

    logic                         exe_to_mem_valid;
    logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus;
    logic                         mem_allowin;
    logic                         mem_to_wb_valid;
    logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus;
    logic                         wb_allowin;
    logic                         data_sram_data_ok;
    logic [DATA_WD-1:0]           data_sram_rdata;
    logic                         gr_we_mem;
    logic [REG_ADDR_WD-1:0]       dest_mem;
    logic [DATA_WD-1:0]           forward_data_mem;
    logic                         mem_load_pending;

    // Surrounding pipeline / environment side
    modport master (
        output exe_to_mem_valid, exe_to_mem_bus, wb_allowin,
               data_sram_data_ok, data_sram_rdata,
        input  mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
               gr_we_mem, dest_mem, forward_data_mem, mem_load_pending
    );

    // Memory stage side
    modport slave (
        input  exe_to_mem_valid, exe_to_mem_bus, wb_allowin,
               data_sram_data_ok, data_sram_rdata,
        output mem_allowin, mem_to_wb_valid, mem_to_wb_bus,
               gr_we_mem, dest_mem, forward_data_mem, mem_load_pending
    );

endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a load word and sign/zero extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [LD_TYPE_WD-1:0] ld_type,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WD-1:0]    rdata,
    output logic [DATA_WD-1:0]    load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select by low address bits, then extend by load type
    always_comb begin
        case (addr_lo)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (ld_type)
            LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   load_data = {24'd0, byte_sel};
            LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
            LD_HU:   load_data = {16'd0, half_sel};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: holds one instruction, waits for its load response, hands it to WB.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mem_stage_if.slave mem_if
);

    mem_state_e         state_q;
    mem_state_e         state_d;
    exe_to_mem_t        in_bus;
    exe_to_mem_t        bus_q;
    mem_to_wb_t         wb_bus;
    logic [DATA_WD-1:0] buf_q;
    logic [DATA_WD-1:0] load_word;
    logic [DATA_WD-1:0] load_data;
    logic [DATA_WD-1:0] final_result;
    logic               mem_valid;
    logic               mem_ready_go;
    logic               allowin;
    logic               in_fire;
    logic               out_fire;
    logic               buf_en;

    assign in_bus = exe_to_mem_t'(mem_if.exe_to_mem_bus);

    // While waiting the response is forwarded straight through; afterwards the buffer is used
    assign load_word = (state_q == ST_WAIT) ? mem_if.data_sram_rdata : buf_q;

    load_align u_load_align (
        .ld_type   (bus_q.ld_type),
        .addr_lo   (bus_q.alu_result[1:0]),
        .rdata     (load_word),
        .load_data (load_data)
    );

    assign final_result = bus_q.res_from_mem ? load_data : bus_q.alu_result;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Instruction and load-data holding registers (contents need no reset)
    always_ff @(posedge clk) begin
        if (in_fire) begin
            bus_q <= in_bus;
        end
        if (buf_en) begin
            buf_q <= mem_if.data_sram_rdata;
        end
    end

    // Handshake, next state and outputs
    always_comb begin
        state_d      = state_q;
        buf_en       = 1'b0;
        mem_valid    = (state_q != ST_EMPTY);
        mem_ready_go = (state_q == ST_READY)
                     || ((state_q == ST_WAIT) && mem_if.data_sram_data_ok);
        allowin      = !mem_valid || (mem_ready_go && mem_if.wb_allowin);
        out_fire     = mem_valid && mem_ready_go && mem_if.wb_allowin;
        in_fire      = mem_if.exe_to_mem_valid && allowin;

        case (state_q)
            ST_WAIT: begin
                if (mem_if.data_sram_data_ok) begin
                    buf_en  = 1'b1;
                    state_d = ST_READY;
                end
            end
            ST_EMPTY, ST_READY: ;
            default: state_d = ST_EMPTY;
        endcase
        if (out_fire) begin
            state_d = ST_EMPTY;
        end
        if (in_fire) begin
            state_d = in_bus.res_from_mem ? ST_WAIT : ST_READY;
        end

        wb_bus.gr_we        = bus_q.gr_we;
        wb_bus.dest         = bus_q.dest;
        wb_bus.final_result = final_result;
        wb_bus.pc           = bus_q.pc;

        mem_if.mem_allowin      = allowin;
        mem_if.mem_to_wb_valid  = mem_valid && mem_ready_go;
        mem_if.mem_to_wb_bus    = wb_bus;
        mem_if.gr_we_mem        = mem_valid && bus_q.gr_we;
        mem_if.dest_mem         = mem_valid ? bus_q.dest : '0;
        mem_if.forward_data_mem = mem_valid ? final_result : '0;
        mem_if.mem_load_pending = (state_q == ST_WAIT) && !mem_if.data_sram_data_ok;
    end

endmodule
